// File: rtl/rotsh_pkg.sv
// Shared types for the iterative rotate/shift engine: operation modes and FSM states.
package rotsh_pkg;

  typedef enum logic [1:0] {
    ROT  = 2'b00,
    LSH  = 2'b01,
    ASH  = 2'b10,
    RSVD = 2'b11
  } rotsh_mode_e;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    BUSY = 2'b01,
    DONE = 2'b10
  } rotsh_state_e;

endpackage

// File: rtl/rotsh_step.sv
// Combinational stage: moves data by k (0..STEP) single-bit positions and reports
// the last bit that crossed the word boundary.
module rotsh_step
  import rotsh_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int STEP  = 1,
  localparam int K_W  = $clog2(STEP + 1)
) (
  input  logic [WIDTH-1:0] data,
  input  logic [K_W-1:0]   k,
  input  logic             dir,
  input  rotsh_mode_e      mode,
  output logic [WIDTH-1:0] result,
  output logic             carry
);

  logic [WIDTH-1:0] stage [STEP+1];
  logic             carry_st [STEP+1];

  assign stage[0]    = data;
  assign carry_st[0] = 1'b0;

  // Chain of single-position movers; stage gi is active only while gi < k.
  for (genvar gi = 0; gi < STEP; gi++) begin : g_stage
    localparam logic [K_W-1:0] IDX = K_W'(gi);
    logic [WIDTH-1:0] prev;
    logic             take;
    logic             fill_l;
    logic             fill_r;

    assign prev   = stage[gi];
    assign take   = (IDX < k);
    assign fill_l = (mode == LSH || mode == ASH) ? 1'b0 : prev[WIDTH-1];
    assign fill_r = (mode == LSH) ? 1'b0 :
                    (mode == ASH) ? prev[WIDTH-1] : prev[0];

    assign stage[gi+1]    = !take ? prev :
                            dir   ? {fill_r, prev[WIDTH-1:1]} : {prev[WIDTH-2:0], fill_l};
    assign carry_st[gi+1] = !take ? carry_st[gi] :
                            dir   ? prev[0] : prev[WIDTH-1];
  end

  assign result = stage[STEP];
  assign carry  = carry_st[STEP];

endmodule

// File: rtl/rotator_shifter_seq.sv
// Iterative rotate / logical / arithmetic shift engine with valid/ready on both sides,
// moving up to STEP positions per BUSY cycle.
module rotator_shifter_seq
  import rotsh_pkg::*;
#(
  parameter int WIDTH  = 8,
  parameter int STEP   = 1,
  localparam int AMT_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic [AMT_W-1:0] in_amt,
  input  logic             in_dir,
  input  logic [1:0]       in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_carry,
  output logic             out_err
);

  localparam int K_W = $clog2(STEP + 1);
  localparam logic [AMT_W:0] STEP_V = (AMT_W + 1)'(STEP);

  rotsh_state_e     state_reg;
  logic [WIDTH-1:0] work_reg;
  logic [AMT_W-1:0] rem_reg;
  logic             dir_reg;
  rotsh_mode_e      mode_reg;
  logic             err_reg;
  logic [WIDTH-1:0] out_data_reg;
  logic             out_carry_reg;
  logic             out_err_reg;

  logic [AMT_W:0]   k_wide;
  logic [AMT_W-1:0] rem_next;
  logic [WIDTH-1:0] step_data;
  logic             step_carry;

  assign k_wide   = ({1'b0, rem_reg} < STEP_V) ? {1'b0, rem_reg} : STEP_V;
  assign rem_next = rem_reg - k_wide[AMT_W-1:0];

  rotsh_step #(
    .WIDTH (WIDTH),
    .STEP  (STEP)
  ) u_step (
    .data   (work_reg),
    .k      (k_wide[K_W-1:0]),
    .dir    (dir_reg),
    .mode   (mode_reg),
    .result (step_data),
    .carry  (step_carry)
  );

  // Results go to a separate output register so a flush leaves the last completed value visible.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg     <= IDLE;
      work_reg      <= '0;
      rem_reg       <= '0;
      dir_reg       <= 1'b0;
      mode_reg      <= ROT;
      err_reg       <= 1'b0;
      out_data_reg  <= '0;
      out_carry_reg <= 1'b0;
      out_err_reg   <= 1'b0;
    end else if (flush) begin
      state_reg <= IDLE;
      rem_reg   <= '0;
    end else begin
      case (state_reg)
        IDLE: begin
          if (in_valid) begin
            work_reg <= in_data;
            rem_reg  <= in_amt;
            dir_reg  <= in_dir;
            mode_reg <= rotsh_mode_e'(in_mode);
            err_reg  <= (in_mode == 2'b11);
            if (in_amt == '0) begin
              out_data_reg  <= in_data;
              out_carry_reg <= 1'b0;
              out_err_reg   <= (in_mode == 2'b11);
              state_reg     <= DONE;
            end else begin
              state_reg <= BUSY;
            end
          end
        end
        BUSY: begin
          work_reg <= step_data;
          rem_reg  <= rem_next;
          if (rem_next == '0) begin
            out_data_reg  <= step_data;
            out_carry_reg <= step_carry;
            out_err_reg   <= err_reg;
            state_reg     <= DONE;
          end
        end
        DONE: begin
          if (out_ready) state_reg <= IDLE;
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  assign in_ready  = rst_n && (state_reg == IDLE);
  assign out_valid = (state_reg == DONE);
  assign out_data  = out_data_reg;
  assign out_carry = out_carry_reg;
  assign out_err   = out_err_reg;

endmodule

// File: tb/tb_rotator_shifter_seq.sv
// Directed bench: STEP=1 and STEP=4 engines share stimulus; table-driven ops plus
// hand-written sequences for back-pressure, flush and mid-op reset.
module tb_rotator_shifter_seq;

  logic       clk = 1'b0;
  logic       rst_n, flush, in_valid, in_dir, out_ready;
  logic [7:0] in_data;
  logic [2:0] in_amt;
  logic [1:0] in_mode;

  logic       in_ready1, out_valid1, out_carry1, out_err1;
  logic [7:0] out_data1;
  logic       in_ready4, out_valid4, out_carry4, out_err4;
  logic [7:0] out_data4;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  rotator_shifter_seq #(.WIDTH(8), .STEP(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready1),
    .in_data(in_data), .in_amt(in_amt), .in_dir(in_dir), .in_mode(in_mode),
    .out_valid(out_valid1), .out_ready(out_ready), .out_data(out_data1),
    .out_carry(out_carry1), .out_err(out_err1)
  );

  rotator_shifter_seq #(.WIDTH(8), .STEP(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid), .in_ready(in_ready4),
    .in_data(in_data), .in_amt(in_amt), .in_dir(in_dir), .in_mode(in_mode),
    .out_valid(out_valid4), .out_ready(out_ready), .out_data(out_data4),
    .out_carry(out_carry4), .out_err(out_err4)
  );

  typedef struct {
    logic [7:0] data;
    logic [2:0] amt;
    logic       dir;
    logic [1:0] mode;
    logic [7:0] exp_data;
    logic       exp_carry;
    logic       exp_err;
    int         lat1;
    int         lat4;
  } vec_t;

  vec_t vecs[13];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, exp);
    end
  endtask

  // Accept one op on both engines, wait (bounded) for each result, then release both.
  task automatic run_op(input logic [7:0] d, input logic [2:0] a, input logic dr, input logic [1:0] m,
                        output logic [7:0] d1, output logic c1, output logic e1, output int l1,
                        output logic [7:0] d4, output logic c4, output logic e4, output int l4);
    @(negedge clk);
    check("in_ready1_idle", 32'(in_ready1), 32'd1);
    check("in_ready4_idle", 32'(in_ready4), 32'd1);
    in_valid = 1'b1; in_data = d; in_amt = a; in_dir = dr; in_mode = m;
    l1 = 0; l4 = 0; d1 = '0; c1 = 1'b0; e1 = 1'b0; d4 = '0; c4 = 1'b0; e4 = 1'b0;
    for (int e = 1; e <= 30 && (l1 == 0 || l4 == 0); e++) begin
      @(negedge clk);
      in_valid = 1'b0; in_data = ~d; in_amt = ~a; in_dir = ~dr; in_mode = ~m;
      if (l1 == 0 && out_valid1) begin
        l1 = e; d1 = out_data1; c1 = out_carry1; e1 = out_err1;
      end
      if (l4 == 0 && out_valid4) begin
        l4 = e; d4 = out_data4; c4 = out_carry4; e4 = out_err4;
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  initial begin
    logic [7:0] d1, d4;
    logic       c1, e1, c4, e4;
    int         l1, l4, seen;

    //            data   amt   dir   mode   exp    c     err   l1 l4
    vecs[0]  = '{8'h81, 3'd1, 1'b0, 2'b00, 8'h03, 1'b1, 1'b0, 2, 2};
    vecs[1]  = '{8'h01, 3'd3, 1'b1, 2'b00, 8'h20, 1'b0, 1'b0, 4, 2};
    vecs[2]  = '{8'h80, 3'd3, 1'b1, 2'b10, 8'hF0, 1'b0, 1'b0, 4, 2};
    vecs[3]  = '{8'h80, 3'd3, 1'b1, 2'b01, 8'h10, 1'b0, 1'b0, 4, 2};
    vecs[4]  = '{8'hFF, 3'd7, 1'b0, 2'b01, 8'h80, 1'b1, 1'b0, 8, 3};
    vecs[5]  = '{8'hA5, 3'd0, 1'b0, 2'b00, 8'hA5, 1'b0, 1'b0, 1, 1};
    vecs[6]  = '{8'hA5, 3'd0, 1'b1, 2'b10, 8'hA5, 1'b0, 1'b0, 1, 1};
    vecs[7]  = '{8'h81, 3'd1, 1'b0, 2'b11, 8'h03, 1'b1, 1'b1, 2, 2};
    vecs[8]  = '{8'h81, 3'd1, 1'b1, 2'b00, 8'hC0, 1'b1, 1'b0, 2, 2};
    vecs[9]  = '{8'h81, 3'd1, 1'b0, 2'b10, 8'h02, 1'b1, 1'b0, 2, 2};
    vecs[10] = '{8'h96, 3'd5, 1'b0, 2'b00, 8'hD2, 1'b0, 1'b0, 6, 3};
    vecs[11] = '{8'hC3, 3'd6, 1'b1, 2'b10, 8'hFF, 1'b0, 1'b0, 7, 3};
    vecs[12] = '{8'h5A, 3'd4, 1'b1, 2'b01, 8'h05, 1'b1, 1'b0, 5, 2};

    rst_n = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = 8'hFF; in_amt = 3'd1;
    in_dir = 1'b0; in_mode = 2'b00; out_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_in_ready1", 32'(in_ready1), 32'd0);
    check("rst_in_ready4", 32'(in_ready4), 32'd0);
    check("rst_out_valid1", 32'(out_valid1), 32'd0);
    check("rst_out_data1", 32'(out_data1), 32'h00);
    check("rst_out_carry1", 32'(out_carry1), 32'd0);
    check("rst_out_err1", 32'(out_err1), 32'd0);
    in_valid = 1'b0;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_rst_in_ready1", 32'(in_ready1), 32'd1);
    $display("reset sequence done");

    for (int i = 0; i < 13; i++) begin
      run_op(vecs[i].data, vecs[i].amt, vecs[i].dir, vecs[i].mode, d1, c1, e1, l1, d4, c4, e4, l4);
      check($sformatf("v%0d_data1", i), 32'(d1), 32'(vecs[i].exp_data));
      check($sformatf("v%0d_carry1", i), 32'(c1), 32'(vecs[i].exp_carry));
      check($sformatf("v%0d_err1", i), 32'(e1), 32'(vecs[i].exp_err));
      check($sformatf("v%0d_lat1", i), 32'(l1), 32'(vecs[i].lat1));
      check($sformatf("v%0d_data4", i), 32'(d4), 32'(vecs[i].exp_data));
      check($sformatf("v%0d_carry4", i), 32'(c4), 32'(vecs[i].exp_carry));
      check($sformatf("v%0d_err4", i), 32'(e4), 32'(vecs[i].exp_err));
      check($sformatf("v%0d_lat4", i), 32'(l4), 32'(vecs[i].lat4));
      $display("op %0d data=%02h amt=%0d dir=%0d mode=%0d -> s1 %02h c%0d e%0d lat%0d | s4 %02h c%0d e%0d lat%0d",
               i, vecs[i].data, vecs[i].amt, vecs[i].dir, vecs[i].mode, d1, c1, e1, l1, d4, c4, e4, l4);
    end

    // Back-pressure: result must hold while out_ready stays low.
    @(negedge clk);
    in_valid = 1'b1; in_data = 8'h81; in_amt = 3'd1; in_dir = 1'b0; in_mode = 2'b00;
    @(negedge clk);
    in_valid = 1'b0; in_data = 8'h00;
    @(negedge clk);
    check("hold_valid_rise", 32'(out_valid1), 32'd1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check("hold_valid", 32'(out_valid1), 32'd1);
      check("hold_data", 32'(out_data1), 32'h03);
      check("hold_carry", 32'(out_carry1), 32'd1);
      check("hold_in_ready", 32'(in_ready1), 32'd0);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("release_in_ready", 32'(in_ready1), 32'd1);
    check("release_valid", 32'(out_valid1), 32'd0);
    $display("backpressure sequence done");

    // Flush mid-op: STEP=1 is still BUSY, STEP=4 has just finished.
    in_valid = 1'b1; in_data = 8'hFF; in_amt = 3'd7; in_dir = 1'b0; in_mode = 2'b01;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    flush = 1'b1;
    @(negedge clk);
    flush = 1'b0;
    check("flush_valid1", 32'(out_valid1), 32'd0);
    check("flush_valid4", 32'(out_valid4), 32'd0);
    check("flush_in_ready1", 32'(in_ready1), 32'd1);
    check("flush_in_ready4", 32'(in_ready4), 32'd1);
    check("flush_data1_held", 32'(out_data1), 32'h03);
    check("flush_data4_held", 32'(out_data4), 32'h80);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid1 || out_valid4) seen++;
    end
    check("flush_no_valid", 32'(seen), 32'd0);
    $display("flush mid-busy sequence done");

    // Flush together with in_valid in IDLE: no accept.
    flush = 1'b1; in_valid = 1'b1; in_data = 8'h3C; in_amt = 3'd0; in_mode = 2'b00;
    #1;
    check("flush_same_in_ready", 32'(in_ready1), 32'd1);
    @(negedge clk);
    flush = 1'b0; in_valid = 1'b0;
    seen = 0;
    repeat (5) begin
      @(negedge clk);
      if (out_valid1 || out_valid4) seen++;
    end
    check("flush_same_no_accept", 32'(seen), 32'd0);
    check("flush_same_data1", 32'(out_data1), 32'h03);
    $display("flush with in_valid sequence done");

    // Reset mid-BUSY.
    in_valid = 1'b1; in_data = 8'h01; in_amt = 3'd7; in_dir = 1'b0; in_mode = 2'b00;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_in_ready", 32'(in_ready1), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    check("midrst_valid1", 32'(out_valid1), 32'd0);
    check("midrst_data1", 32'(out_data1), 32'h00);
    check("midrst_valid4", 32'(out_valid4), 32'd0);
    seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (out_valid1 || out_valid4) seen++;
    end
    check("midrst_no_valid", 32'(seen), 32'd0);
    run_op(8'h81, 3'd1, 1'b0, 2'b00, d1, c1, e1, l1, d4, c4, e4, l4);
    check("after_rst_data1", 32'(d1), 32'h03);
    check("after_rst_lat1", 32'(l1), 32'd2);
    check("after_rst_data4", 32'(d4), 32'h03);
    $display("reset mid-busy sequence done: s1 %02h lat%0d", d1, l1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
